sub_bytes_scheduler: RTL and testbench

//   Time-multiplexes SBOX_COUNT Byte_Substitution instances over the 16 bytes of a 128-bit AES state.

---
 rtl/sub_bytes_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_sub_bytes_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_scheduler.sv
// sub_bytes_scheduler
// Time-multiplexes SBOX_COUNT AES S-box lanes over the 16 bytes of a 128-bit
// state, so one full SubBytes takes PASSES = 16/SBOX_COUNT cycles.
// Optional feature macro: KEY_SUBWORD_EN. When defined, the same S-box lanes
// are also shared with the key schedule's 32-bit SubWord; key requests win
// over state requests in IDLE.
// Legal SBOX_COUNT values: 1, 2, 4, 8, 16.

module sub_bytes_scheduler #(
  parameter int SBOX_COUNT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
`ifdef KEY_SUBWORD_EN
  ,
  input  logic         kw_valid,
  output logic         kw_ready,
  input  logic [31:0]  kw_word,
  output logic         kw_out_valid,
  output logic [31:0]  kw_result
`endif
);

  localparam int PASSES = 16 / SBOX_COUNT;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

`ifdef KEY_SUBWORD_EN
  localparam int WORD_LANES  = (SBOX_COUNT < 4) ? SBOX_COUNT : 4;
  localparam int WORD_PASSES = 4 / WORD_LANES;
  localparam logic [CNT_W-1:0] LAST_WPASS = CNT_W'(WORD_PASSES - 1);
`endif

  // AES forward S-box; entry 0x00 is the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Because entry 0 sits at the top of the table, ~b selects the right slot.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

`ifdef KEY_SUBWORD_EN
  typedef enum logic [1:0] {IDLE, SUB, DONE, WORD} state_t;
`else
  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] pass_cnt;
  logic [127:0]     state_buf;
  logic [7:0]       lane_in  [SBOX_COUNT];
  logic [7:0]       lane_out [SBOX_COUNT];

`ifdef KEY_SUBWORD_EN
  logic [31:0]      kw_buf;
  logic [31:0]      kw_next;
`endif

  // Handshake and status flags are pure decodes of the FSM state so that
  // ready is high in the very first cycle after reset.
`ifdef KEY_SUBWORD_EN
  assign in_ready = (state == IDLE) && !kw_valid;
  assign kw_ready = (state == IDLE);
`else
  assign in_ready = (state == IDLE);
`endif
  assign busy = (state != IDLE);

  // Lane input select: the current slice of the latched state, or in WORD
  // the current slice of the latched key word on the low lanes.
  always_comb begin
    for (int j = 0; j < SBOX_COUNT; j++) begin
      lane_in[j] = state_buf[(int'(pass_cnt) * SBOX_COUNT + j) * 8 +: 8];
`ifdef KEY_SUBWORD_EN
      if (state == WORD && j < WORD_LANES)
        lane_in[j] = kw_buf[((int'(pass_cnt) % WORD_PASSES) * WORD_LANES + j) * 8 +: 8];
`endif
    end
  end

  // One S-box per lane.
  for (genvar g = 0; g < SBOX_COUNT; g++) begin : g_lane
    assign lane_out[g] = sbox(lane_in[g]);
  end

`ifdef KEY_SUBWORD_EN
  // Key word with the bytes of the current WORD pass already substituted.
  always_comb begin
    kw_next = kw_buf;
    for (int j = 0; j < WORD_LANES; j++)
      kw_next[((int'(pass_cnt) % WORD_PASSES) * WORD_LANES + j) * 8 +: 8] = lane_out[j];
  end
`endif

  // Main FSM: accept, substitute one slice per cycle, then hold the result
  // until downstream takes it. Reset discards any partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pass_cnt     <= '0;
      out_valid    <= 1'b0;
      out_state    <= '0;
      state_buf    <= '0;
`ifdef KEY_SUBWORD_EN
      kw_buf       <= '0;
      kw_out_valid <= 1'b0;
      kw_result    <= '0;
`endif
    end else begin
`ifdef KEY_SUBWORD_EN
      kw_out_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef KEY_SUBWORD_EN
          if (kw_valid) begin
            kw_buf   <= kw_word;
            pass_cnt <= '0;
            state    <= WORD;
          end else
`endif
          if (in_valid) begin
            state_buf <= in_state;
            pass_cnt  <= '0;
            state     <= SUB;
          end
        end
        SUB: begin
          for (int j = 0; j < SBOX_COUNT; j++)
            out_state[(int'(pass_cnt) * SBOX_COUNT + j) * 8 +: 8] <= lane_out[j];
          if (pass_cnt == LAST_PASS) begin
            pass_cnt  <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            pass_cnt <= pass_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
`ifdef KEY_SUBWORD_EN
        WORD: begin
          kw_buf <= kw_next;
          if (pass_cnt == LAST_WPASS) begin
            kw_result    <= kw_next;
            kw_out_valid <= 1'b1;
            pass_cnt     <= '0;
            state        <= IDLE;
          end else begin
            pass_cnt <= pass_cnt + CNT_W'(1);
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_scheduler.sv
// Directed testbench for sub_bytes_scheduler: main instance with
// SBOX_COUNT=4, plus SBOX_COUNT=1 and 16 instances for the latency checks.
// The key-word section is compiled only when KEY_SUBWORD_EN is defined.

module tb_sub_bytes_scheduler;

  localparam logic [127:0] VEC_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [127:0] ZERO_OUT = {16{8'h63}};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_state = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_state;

  logic         in_valid_b = 1'b0;
  logic         out_ready_b = 1'b1;
  logic         x1_in_ready, x1_out_valid, x1_busy;
  logic [127:0] x1_out_state;
  logic         x16_in_ready, x16_out_valid, x16_busy;
  logic [127:0] x16_out_state;

`ifdef KEY_SUBWORD_EN
  logic         kw_valid = 1'b0;
  logic [31:0]  kw_word = '0;
  logic         kw_ready, kw_out_valid;
  logic [31:0]  kw_result;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  sub_bytes_scheduler #(.SBOX_COUNT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy)
`ifdef KEY_SUBWORD_EN
    ,
    .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_word(kw_word),
    .kw_out_valid(kw_out_valid), .kw_result(kw_result)
`endif
  );

  sub_bytes_scheduler #(.SBOX_COUNT(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(x1_in_ready), .in_state(in_state),
    .out_valid(x1_out_valid), .out_ready(out_ready_b), .out_state(x1_out_state),
    .busy(x1_busy)
`ifdef KEY_SUBWORD_EN
    ,
    .kw_valid(1'b0), .kw_ready(), .kw_word(32'h0),
    .kw_out_valid(), .kw_result()
`endif
  );

  sub_bytes_scheduler #(.SBOX_COUNT(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(x16_in_ready), .in_state(in_state),
    .out_valid(x16_out_valid), .out_ready(out_ready_b), .out_state(x16_out_state),
    .busy(x16_busy)
`ifdef KEY_SUBWORD_EN
    ,
    .kw_valid(1'b0), .kw_ready(), .kw_word(32'h0),
    .kw_out_valid(), .kw_result()
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [127:0] s);
    in_valid = v;
    in_state = s;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence of all scenarios.
  initial begin
    // Reset and all-zero state.
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("rst_out_valid", 128'(out_valid), 128'(1'b0));
    checkOutput("rst_out_state", out_state, 128'h0);
    checkOutput("rst_busy", 128'(busy), 128'(1'b0));
    checkOutput("rst_in_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b0;
    applyStimulus(1'b1, 128'h0);
    tick();
    applyStimulus(1'b0, 128'h0);
    checkOutput("t1_busy", 128'(busy), 128'(1'b1));
    checkOutput("t1_in_ready_sub", 128'(in_ready), 128'(1'b0));
    repeat (3) tick();
    checkOutput("t1_valid_early", 128'(out_valid), 128'(1'b0));
    tick();
    checkOutput("t1_valid_lat4", 128'(out_valid), 128'(1'b1));
    checkOutput("t1_out_state", out_state, ZERO_OUT);
    out_ready = 1'b1;
    tick();
    checkOutput("t1_drain_valid", 128'(out_valid), 128'(1'b0));

    // Reference vector; input changes after handshake must not matter.
    applyStimulus(1'b1, VEC_IN);
    tick();
    applyStimulus(1'b0, {128{1'b1}});
    repeat (3) tick();
    checkOutput("t2_valid_early", 128'(out_valid), 128'(1'b0));
    tick();
    checkOutput("t2_valid_lat4", 128'(out_valid), 128'(1'b1));
    checkOutput("t2_out_state", out_state, VEC_OUT);
    checkOutput("t2_in_ready_done", 128'(in_ready), 128'(1'b0));
    tick();
    checkOutput("t2_in_ready_back", 128'(in_ready), 128'(1'b1));
    checkOutput("t2_valid_clear", 128'(out_valid), 128'(1'b0));

    // Backpressure: result held stable while out_ready is low.
    out_ready = 1'b0;
    applyStimulus(1'b1, VEC_IN);
    tick();
    applyStimulus(1'b0, 128'h0);
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t3_hold_valid", 128'(out_valid), 128'(1'b1));
      checkOutput("t3_hold_state", out_state, VEC_OUT);
      checkOutput("t3_hold_in_ready", 128'(in_ready), 128'(1'b0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    checkOutput("t3_one_xfer", 128'(out_valid), 128'(1'b0));
    tick();
    checkOutput("t3_no_second", 128'(out_valid), 128'(1'b0));
    checkOutput("t3_idle_ready", 128'(in_ready), 128'(1'b1));

    // Reset during the second SUB cycle discards everything.
    applyStimulus(1'b1, VEC_IN);
    tick();
    applyStimulus(1'b0, 128'h0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t4_valid", 128'(out_valid), 128'(1'b0));
    checkOutput("t4_state", out_state, 128'h0);
    checkOutput("t4_busy", 128'(busy), 128'(1'b0));
    checkOutput("t4_in_ready", 128'(in_ready), 128'(1'b1));
    applyStimulus(1'b1, 128'h0);
    tick();
    applyStimulus(1'b0, 128'h0);
    repeat (4) tick();
    checkOutput("t4_new_valid", 128'(out_valid), 128'(1'b1));
    checkOutput("t4_new_state", out_state, ZERO_OUT);
    tick();

    // Latency with 1 and 16 lanes.
    in_state = VEC_IN;
    in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0;
    checkOutput("t5_x16_early", 128'(x16_out_valid), 128'(1'b0));
    tick();
    checkOutput("t5_x16_lat1", 128'(x16_out_valid), 128'(1'b1));
    checkOutput("t5_x16_state", x16_out_state, VEC_OUT);
    repeat (14) tick();
    checkOutput("t5_x1_early", 128'(x1_out_valid), 128'(1'b0));
    tick();
    checkOutput("t5_x1_lat16", 128'(x1_out_valid), 128'(1'b1));
    checkOutput("t5_x1_state", x1_out_state, VEC_OUT);
    tick();

`ifdef KEY_SUBWORD_EN
    // Key word request beats a simultaneous state request.
    kw_valid = 1'b1;
    kw_word  = 32'hcf4f3c09;
    applyStimulus(1'b1, VEC_IN);
    #1;
    checkOutput("t6_kw_ready", 128'(kw_ready), 128'(1'b1));
    checkOutput("t6_in_ready_blk", 128'(in_ready), 128'(1'b0));
    tick();
    kw_valid = 1'b0;
    checkOutput("t6_kw_early", 128'(kw_out_valid), 128'(1'b0));
    tick();
    checkOutput("t6_kw_pulse", 128'(kw_out_valid), 128'(1'b1));
    checkOutput("t6_kw_result", 128'(kw_result), 128'(32'h8a84eb01));
    checkOutput("t6_in_ready", 128'(in_ready), 128'(1'b1));
    tick();
    applyStimulus(1'b0, 128'h0);
    checkOutput("t6_kw_pulse_end", 128'(kw_out_valid), 128'(1'b0));
    checkOutput("t6_kw_held", 128'(kw_result), 128'(32'h8a84eb01));
    checkOutput("t6_busy", 128'(busy), 128'(1'b1));
    repeat (4) tick();
    checkOutput("t6_state_valid", 128'(out_valid), 128'(1'b1));
    checkOutput("t6_state_out", out_state, VEC_OUT);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
